// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: the single-port unified memory of pipe_MIPS32 is shared by
// three requesters: the MEM-stage data port (D), the IF-stage fetch port (F)
// and the program loader (L). L is only honoured while the core is halted.
// Each access runs a fixed sequence IDLE -> ISSUE -> WAIT (MEM_LAT) -> DONE.
// Arbitration uses fixed priority L > D > F, with a starvation guard that
// hands the port to F after STARVE_MAX consecutive lost arbitrations.
// Define MIPS_MEM_ARB_STATS_EN to build the 16-bit saturating conflict
// counter on stat_conflicts. Without it, stat_conflicts is tied to zero.
module mips_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              halted_i,
   input  logic              d_req,
   input  logic              f_req,
   input  logic              l_req,
   input  logic              d_we,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              d_gnt,
   output logic              f_gnt,
   output logic              l_gnt,
   output logic              d_done,
   output logic              f_done,
   output logic              l_done,
   output logic [DATA_W-1:0] rdata_o,
   output logic              busy_o,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stat_conflicts
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

   // Requester select, one-hot in the order {L, F, D}.
   localparam logic [2:0] SEL_D = 3'b001;
   localparam logic [2:0] SEL_F = 3'b010;
   localparam logic [2:0] SEL_L = 3'b100;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic              wr_q, wr_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [2:0]        done_q, done_d;
   logic              busy_q, busy_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              l_vld;

   function automatic logic [STV_W-1:0] starve_sat_inc(input logic [STV_W-1:0] c);
      return (c == STV_SAT) ? c : c + STV_W'(1);
   endfunction

   // A loader request is only a real request while the core is halted.
   assign l_vld = l_req & halted_i;

   // Next-state logic: arbitration in IDLE, fixed-length access sequence after.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      wr_d     = wr_q;
      lat_d    = lat_q;
      starve_d = starve_q;
      gnt_d    = '0;
      done_d   = '0;
      busy_d   = busy_q;
      en_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (l_vld)                             sel_d = SEL_L;
            else if (f_req && starve_q == STV_SAT) sel_d = SEL_F;
            else if (d_req)                        sel_d = SEL_D;
            else if (f_req)                        sel_d = SEL_F;
            else                                   sel_d = '0;
            // Losses only count while F is actually waiting.
            if (!f_req)              starve_d = '0;
            else if (sel_d == SEL_F) starve_d = '0;
            else if (sel_d != '0)    starve_d = starve_sat_inc(starve_q);
            if (sel_d != '0) begin
               state_d = ISSUE;
               busy_d  = 1'b1;
               gnt_d   = sel_d;
               en_d    = 1'b1;
               if (sel_d == SEL_L) begin
                  we_d    = l_we;
                  addr_d  = l_addr;
                  wdata_d = l_wdata;
               end else if (sel_d == SEL_F) begin
                  we_d    = 1'b0;
                  addr_d  = f_addr;
                  wdata_d = '0;
               end else begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end
               wr_d = we_d;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            lat_d   = '0;
         end
         WAIT: begin
            // Last WAIT cycle is ISSUE+MEM_LAT, where read data is valid.
            if (lat_q == LAT_LAST) begin
               state_d = DONE;
               done_d  = sel_q;
               if (!wr_q) rdata_d = mem_rdata;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         wr_q     <= 1'b0;
         lat_q    <= '0;
         starve_q <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         wr_q     <= wr_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign {l_gnt, f_gnt, d_gnt}    = gnt_q;
   assign {l_done, f_done, d_done} = done_q;
   assign busy_o    = busy_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata_o   = rdata_q;

`ifdef MIPS_MEM_ARB_STATS_EN
   logic [15:0] stat_q;
   logic        multi_req;

   function automatic logic [15:0] stat_sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Any IDLE cycle with two or more valid requests produces a contested grant.
   assign multi_req = (d_req & f_req) | (d_req & l_vld) | (f_req & l_vld);

   // Count contested grants, saturating.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset)                              stat_q <= '0;
      else if (state_q == IDLE && multi_req)  stat_q <= stat_sat_inc(stat_q);
   end

   assign stat_conflicts = stat_q;
`else
   assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each attached to its own small behavioural memory.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

   typedef struct packed {
      logic        d, f, l, h, dwe, lwe;
      logic [9:0]  da, fa, la;
      logic [31:0] dwd, lwd;
   } in_t;

   typedef struct packed {
      logic [2:0]  gnt;
      logic [2:0]  done;
      logic        busy, en, we;
      logic [9:0]  addr;
      logic [31:0] wd, rd;
      logic [15:0] st;
   } obs_t;

   typedef struct packed {
      in_t         in;
      logic [2:0]  g;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wd, rd;
   } vec_t;

   logic clk1 = 1'b0;
   logic reset = 1'b1;
   in_t  ia = '0, ib = '0;
   int   n_pass = 0, n_tot = 0;

   logic        a_dg, a_fg, a_lg, a_dd, a_fd, a_ld, a_busy, a_en, a_we;
   logic [9:0]  a_addr;
   logic [31:0] a_wd, a_rd, rd_a;
   logic [15:0] a_st;
   logic        b_dg, b_fg, b_lg, b_dd, b_fd, b_ld, b_busy, b_en, b_we;
   logic [9:0]  b_addr;
   logic [31:0] b_wd, b_rd, pb0, pb1, pb2;
   logic [15:0] b_st;
   obs_t        oa, ob;
   logic [31:0] mem_a[16];
   logic [31:0] mem_b[16];

   always #5 clk1 = ~clk1;

   mips_mem_arbiter #(.MEM_LAT(1)) u_a (
      .clk1(clk1), .reset(reset), .halted_i(ia.h),
      .d_req(ia.d), .f_req(ia.f), .l_req(ia.l), .d_we(ia.dwe), .l_we(ia.lwe),
      .d_addr(ia.da), .f_addr(ia.fa), .l_addr(ia.la),
      .d_wdata(ia.dwd), .l_wdata(ia.lwd),
      .d_gnt(a_dg), .f_gnt(a_fg), .l_gnt(a_lg),
      .d_done(a_dd), .f_done(a_fd), .l_done(a_ld),
      .rdata_o(a_rd), .busy_o(a_busy), .mem_en(a_en), .mem_we(a_we),
      .mem_addr(a_addr), .mem_wdata(a_wd), .mem_rdata(rd_a),
      .stat_conflicts(a_st));

   mips_mem_arbiter #(.MEM_LAT(3)) u_b (
      .clk1(clk1), .reset(reset), .halted_i(ib.h),
      .d_req(ib.d), .f_req(ib.f), .l_req(ib.l), .d_we(ib.dwe), .l_we(ib.lwe),
      .d_addr(ib.da), .f_addr(ib.fa), .l_addr(ib.la),
      .d_wdata(ib.dwd), .l_wdata(ib.lwd),
      .d_gnt(b_dg), .f_gnt(b_fg), .l_gnt(b_lg),
      .d_done(b_dd), .f_done(b_fd), .l_done(b_ld),
      .rdata_o(b_rd), .busy_o(b_busy), .mem_en(b_en), .mem_we(b_we),
      .mem_addr(b_addr), .mem_wdata(b_wd), .mem_rdata(pb2),
      .stat_conflicts(b_st));

   assign oa = {{a_lg, a_fg, a_dg}, {a_ld, a_fd, a_dd}, a_busy, a_en, a_we, a_addr, a_wd, a_rd, a_st};
   assign ob = {{b_lg, b_fg, b_dg}, {b_ld, b_fd, b_dd}, b_busy, b_en, b_we, b_addr, b_wd, b_rd, b_st};

   function automatic logic [31:0] init_a(input int i);
      return (i == 5) ? 32'h00222000 : (32'hA0000000 | 32'(i));
   endfunction

   function automatic logic [31:0] init_b(input int i);
      return 32'hB0000000 + 32'(i) * 32'h11;
   endfunction

   // Memory A: one-cycle synchronous read.
   always @(posedge clk1) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= init_a(i);
      end else if (a_en) begin
         if (a_we) mem_a[a_addr[3:0]] <= a_wd;
         rd_a <= mem_a[a_addr[3:0]];
      end
   end

   // Memory B: three-cycle read pipeline.
   always @(posedge clk1) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= init_b(i);
      end else begin
         if (b_en && b_we) mem_b[b_addr[3:0]] <= b_wd;
         if (b_en) pb0 <= mem_b[b_addr[3:0]];
         pb1 <= pb0;
         pb2 <= pb1;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
   endtask

   task automatic drive(input int u, input in_t v);
      if (u == 0) ia = v;
      else        ib = v;
   endtask

   function automatic obs_t obs(input int u);
      return (u == 0) ? oa : ob;
   endfunction

   function automatic in_t mk(input logic d, f, l, h, dwe, lwe,
                              input logic [9:0] da, fa, la,
                              input logic [31:0] dwd, lwd);
      in_t v;
      v = {d, f, l, h, dwe, lwe, da, fa, la, dwd, lwd};
      return v;
   endfunction

   // Issue one access from IDLE and check grant, memory strobe, latency, data.
   task automatic run_access(input int u, input in_t v, input logic [2:0] g,
                             input logic we, input logic [9:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int lat, input string nm);
      obs_t o;
      in_t  z;
      int   n;
      drive(u, v);
      @(posedge clk1); #1;
      o = obs(u);
      chk({nm, "_gnt"}, o.gnt, g);
      chk({nm, "_issue"}, {o.en, o.we, o.addr, o.wd, o.busy},
          {1'b1, we, addr, wd, 1'b1});
      z = '0;
      z.h = v.h;
      drive(u, z);
      n = 1;
      while (o.done == 3'b000 && n < 12) begin
         @(posedge clk1); #1;
         n++;
         o = obs(u);
      end
      chk({nm, "_lat"}, n, lat + 2);
      chk({nm, "_done"}, {o.done, o.rd}, {g, rd});
      @(posedge clk1); #1;
      o = obs(u);
      chk({nm, "_idle"}, {o.busy, o.done, o.gnt, o.en}, 8'h00);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout n_pass=%0d n_tot=%0d", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      vec_t        tbl[8];
      in_t         v;
      logic [2:0]  order[5];
      logic [15:0] exp_st;
      int          n, bad;

      //          d  f  l  h  dwe lwe  da  fa  la  dwd            lwd
      tbl[0] = '{mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0),               3'b010, 0, 5, 0, 32'h00222000};
      tbl[1] = '{mk(1, 1, 0, 0, 1, 0, 3, 3, 0, 32'h55, 0),          3'b001, 1, 3, 32'h55, 32'h00222000};
      tbl[2] = '{mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0),               3'b010, 0, 3, 0, 32'h00000055};
      tbl[3] = '{mk(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0),               3'b001, 0, 7, 0, 32'hA0000007};
      tbl[4] = '{mk(1, 0, 1, 0, 0, 1, 2, 0, 9, 0, 32'h77),          3'b001, 0, 2, 0, 32'hA0000002};
      tbl[5] = '{mk(1, 1, 1, 1, 0, 1, 0, 0, 8, 0, 32'h1234),        3'b100, 1, 8, 32'h1234, 32'hA0000002};
      tbl[6] = '{mk(1, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0),               3'b001, 0, 8, 0, 32'h00001234};
      tbl[7] = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 5, 0, 0),               3'b100, 0, 5, 0, 32'h00222000};

      reset = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      chk("reset_a", oa, '0);
      chk("reset_b", ob, '0);
      reset = 1'b0;
      @(posedge clk1); #1;

      for (int k = 0; k < 8; k++)
         run_access(0, tbl[k].in, tbl[k].g, tbl[k].we, tbl[k].addr,
                    tbl[k].wd, tbl[k].rd, 1, $sformatf("vec%0d", k));

`ifdef MIPS_MEM_ARB_STATS_EN
      exp_st = 16'd2;
`else
      exp_st = 16'd0;
`endif
      chk("stat_conflicts", a_st, exp_st);

      // Loader request without halt is ignored entirely.
      v = mk(0, 0, 1, 0, 0, 1, 0, 0, 8, 0, 32'hfc000000);
      drive(0, v);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk1); #1;
         if (a_lg || a_en || a_busy) bad++;
      end
      chk("lreq_nohalt", bad, 0);
      v.h = 1'b1;
      run_access(0, v, 3'b100, 1, 8, 32'hfc000000, 32'h00222000, 1, "lwrite");
      chk("lwrite_mem", mem_a[8], 32'hfc000000);

      // D and F both held: starvation guard gives D, D, D, F, then D again.
      order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001;
      order[3] = 3'b010; order[4] = 3'b001;
      v = mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      drive(0, v);
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            @(posedge clk1); #1;
            n++;
         end while ({a_lg, a_fg, a_dg} == 3'b000 && n < 12);
         chk($sformatf("starve_gnt%0d", k), {a_lg, a_fg, a_dg}, order[k]);
      end
      drive(0, '0);
      repeat (6) @(posedge clk1);
      #1;
      chk("starve_idle", {a_busy, a_en}, 2'b00);

      // Reset in the middle of a MEM_LAT=3 read abandons it.
      v = mk(1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
      drive(1, v);
      @(posedge clk1); #1;
      chk("rstmid_gnt", {b_lg, b_fg, b_dg}, 3'b001);
      drive(1, '0);
      repeat (2) @(posedge clk1);
      #1;
      chk("rstmid_wait", {b_busy, b_en, b_dd}, 3'b100);
      reset = 1'b1;
      #1;
      chk("rstmid_b", ob, '0);
      chk("rstmid_a", oa, '0);
      @(posedge clk1); #1;
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk1); #1;
         if (b_dd || b_busy) bad++;
      end
      chk("rstmid_nodone", bad, 0);
      run_access(1, mk(0, 1, 0, 0, 0, 0, 0, 6, 0, 0, 0), 3'b010, 0, 6, 0,
                 init_b(6), 3, "after_rst");

      // MEM_LAT=3 read sweep.
      for (int a = 0; a < 8; a++)
         run_access(1, mk(0, 1, 0, 0, 0, 0, 0, 10'(a), 0, 0, 0), 3'b010, 0,
                    10'(a), 0, init_b(a), 3, $sformatf("sweep%0d", a));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory of pipe_MIPS32 between three requesters.
- Requesters: the MEM-stage load/store port (D), the IF-stage fetch port (F), and a program loader port (L).
- The loader writes the program image while the core is halted.
- Runs a fixed-latency memory access sequence, with fixed priority plus a starvation guard for fetch.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (min 1).
- STARVE_MAX, 3, number of consecutive lost arbitrations after which F wins.

Ports:
- clk1 in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- halted_i in 1: core HALTED flag; enables the L port.
- d_req, f_req, l_req in 1 each: requests, held until grant.
- d_we, l_we in 1 each: write enable (F is read-only).
- d_addr, f_addr, l_addr in ADDR_W each: word address.
- d_wdata, l_wdata in DATA_W each: write data.
- d_gnt, f_gnt, l_gnt out 1 each: one-cycle grant pulse.
- d_done, f_done, l_done out 1 each: one-cycle completion pulse.
- rdata_o out DATA_W: read data, valid with x_done.
- busy_o out 1: high in any state other than IDLE.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_rdata in DATA_W: memory read data.
- stat_conflicts out 16: conflict counter (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset (async): state=IDLE; starve_cnt=0.
- Reset values: all gnt/done/mem_en/mem_we = 0; mem_addr, mem_wdata, rdata_o = 0; busy_o = 0; stat_conflicts = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration evaluated on each edge, in order:
  1. l_req && halted_i → L.
  2. f_req && starve_cnt==STARVE_MAX → F.
  3. d_req → D.
  4. f_req → F.
  5. None → stay in IDLE.
- l_req while halted_i=0 is ignored (no grant) and does not count as a conflict.
- On a grant, go to ISSUE.
- ISSUE, one cycle:
  - Winner's x_gnt=1 and mem_en=1.
  - mem_we = winner's we; mem_addr and mem_wdata = winner's values.
  - Next state is WAIT.
- WAIT: mem_en=0; count MEM_LAT cycles from the ISSUE cycle.
- The cycle in which mem_rdata is valid is ISSUE+MEM_LAT; mem_rdata is captured into rdata_o at the end of that cycle, then go to DONE.
- For writes, rdata_o holds its previous value.
- DONE, one cycle: winner's x_done=1; next state is IDLE.
- rdata_o holds until the next read capture.
- Latency: request seen at edge E → gnt in cycle E+1 → done in cycle E+MEM_LAT+2.
- Throughput: one access per MEM_LAT+3 cycles.
- Requests are sampled only in IDLE. Changes to requester inputs during ISSUE/WAIT/DONE do not affect the access in flight.
- Requesters must keep req and address stable until gnt; they must deassert req in the cycle after gnt unless issuing a new access.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) at each IDLE grant to D or L while f_req=1.
  - Cleared on a grant to F.
  - Cleared on any IDLE cycle with f_req=0.
- halted_i falling during an in-flight L access: the access completes normally.
- Reset asserted mid-access: the access is abandoned immediately, no done pulse, all counters cleared.
- Exactly one x_gnt is ever high at a time; likewise for x_done.

Optional Feature:
- Macro: MIPS_MEM_ARB_STATS_EN.
- Defined: stat_conflicts is a 16-bit saturating counter.
  - +1 at each IDLE grant where two or more valid requests were present.
  - A valid request is d_req, f_req, or l_req&&halted_i.
  - Cleared only by reset.
- Not defined: stat_conflicts is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, then single F read at addr 5, memory holds 32'h00222000, MEM_LAT=1 → f_gnt one cycle after the req edge, mem_en one cycle, f_done 3 cycles after the req edge, rdata_o=32'h00222000, busy_o back to 0.
- d_req (write 0x55 to addr 3) and f_req asserted together, STARVE_MAX=3 → D served first, then F; a following read of addr 3 returns 32'h00000055; with the macro defined, stat_conflicts=1.
- d_req held continuously and f_req held → D, D, D, F grant order (starve guard fires after 3 losses); starve_cnt clears after F is served.
- l_req with halted_i=0 for 10 cycles → no l_gnt, no mem_en. Then halted_i=1 with l_req writing 32'hfc000000 to addr 8 → l_gnt and l_done, memory addr 8 updated.
- Reset asserted during WAIT of a D read (MEM_LAT=3) → all outputs 0 immediately, no d_done; after release a new F request is granted normally.
- MEM_LAT=3 read sweep over addr 0..7 → each done exactly 5 cycles after its req edge, rdata_o matches the memory image.
